// File: rtl/seq_word_serializer.sv
// Parallel-to-serial word feeder for the 1010 sequence detector.
// A one-word holding buffer lets the next word follow with no idle gap on x.
module seq_word_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic             x,
    output logic             x_valid,
    output logic             x_last,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_vld_q, hold_vld_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             x_q, x_d;
    logic             x_valid_q, x_valid_d;
    logic             x_last_q, x_last_d;

    logic             accept;
    logic             load_en;
    logic [WIDTH-1:0] load_word;
    logic [WIDTH-1:0] next_word;

    // Bit currently at the transmit end of a word image.
    function automatic logic head_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    // Moves the following bit to the transmit end.
    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    assign in_ready  = !hold_vld_q && !flush;
    assign accept    = in_valid && in_ready;
    assign busy      = (state_q == SHIFT) || hold_vld_q;
    assign next_word = advance(shift_q);

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        bit_cnt_d  = bit_cnt_q;
        x_d        = IDLE_BIT;
        x_valid_d  = 1'b0;
        load_en    = 1'b0;
        load_word  = in_data;

        if (flush) begin
            state_d    = IDLE;
            hold_vld_d = 1'b0;
            bit_cnt_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        load_en = 1'b1;
                    end
                end
                SHIFT: begin
                    if (bit_cnt_q != LAST_CNT) begin
                        shift_d   = next_word;
                        x_d       = head_bit(next_word);
                        x_valid_d = 1'b1;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (accept) begin
                            hold_d     = in_data;
                            hold_vld_d = 1'b1;
                        end
                    end else if (hold_vld_q) begin
                        // Held word has priority; in_ready is low so nothing new arrives.
                        load_en    = 1'b1;
                        load_word  = hold_q;
                        hold_vld_d = 1'b0;
                    end else if (accept) begin
                        load_en = 1'b1;
                    end else begin
                        state_d   = IDLE;
                        bit_cnt_d = '0;
                    end
                end
                default: begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                end
            endcase
        end

        if (load_en) begin
            state_d   = SHIFT;
            shift_d   = load_word;
            x_d       = head_bit(load_word);
            x_valid_d = 1'b1;
            bit_cnt_d = '0;
        end

        x_last_d = x_valid_d && (bit_cnt_d == LAST_CNT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            hold_vld_q <= 1'b0;
            bit_cnt_q  <= '0;
            x_q        <= IDLE_BIT;
            x_valid_q  <= 1'b0;
            x_last_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_vld_q <= hold_vld_d;
            bit_cnt_q  <= bit_cnt_d;
            x_q        <= x_d;
            x_valid_q  <= x_valid_d;
            x_last_q   <= x_last_d;
        end
    end

    // Word images carry no meaning unless the control state says so.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
        hold_q  <= hold_d;
    end

    assign x       = x_q;
    assign x_valid = x_valid_q;
    assign x_last  = x_last_q;

endmodule
